seg7_scan_multi: RTL and testbench

SEG7_SCAN_MULTI -- requirements
Module: seg7_scan_multi

---
 rtl/seg7_scan_multi.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_multi.sv
// Time-multiplexed hex 7-segment driver with PWM brightness and frame-synchronous loads.
// Define SEG7_LZ_SUPPRESS_EN to blank leading-zero digits.
module seg7_scan_multi #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DIV_BITS    = 18,
    parameter int unsigned BRIGHT_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*DIGITS-1:0]    value,
    input  logic [DIGITS-1:0]      dp_in,
    input  logic [DIGITS-1:0]      digit_en,
    input  logic                   load,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [6:0]             a_to_g,
    output logic                   dp,
    output logic [DIGITS-1:0]      an,
    output logic                   frame_done,
    output logic                   load_ack
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_BITS-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   slot_tick, wrap_tick;

    logic [4*DIGITS-1:0]    pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]      pend_en_q, pend_en_d, disp_en_q, disp_en_d;
    logic                   pend_flag_q, pend_flag_d;

    logic [6:0]             seg_d, seg_raw;
    logic                   dp_d, lit, duty_on;
    logic [DIGITS-1:0]      an_d, lz_blank;
    logic [3:0]             nibble;
    logic [BRIGHT_BITS-1:0] duty_phase;

    assign slot_tick = &presc_q;
    assign wrap_tick = slot_tick && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        presc_d = presc_q + DIV_BITS'(1);
        idx_d   = idx_q;
        if (slot_tick) begin
            idx_d = wrap_tick ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pending data is committed only at a frame boundary, using the flag as it stood
    // before this cycle; a coincident load always lands in pending for the next frame.
    always_comb begin
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_en_d   = disp_en_q;
        if (wrap_tick && pend_flag_q) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            disp_en_d   = pend_en_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_in;
            pend_en_d   = digit_en;
            pend_flag_d = 1'b1;
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    logic above_zero;

    always_comb begin
        lz_blank   = '0;
        above_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            above_zero  = above_zero && (disp_val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = above_zero && !disp_dp_q[i];
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign nibble     = disp_val_q[4*int'(idx_q) +: 4];
    assign duty_phase = presc_q[DIV_BITS-1 -: BRIGHT_BITS];
    assign duty_on    = duty_phase < brightness;

    always_comb begin
        seg_raw = '0;
        unique case (nibble)
            4'h0: seg_raw = 7'h3F;
            4'h1: seg_raw = 7'h06;
            4'h2: seg_raw = 7'h5B;
            4'h3: seg_raw = 7'h4F;
            4'h4: seg_raw = 7'h66;
            4'h5: seg_raw = 7'h6D;
            4'h6: seg_raw = 7'h7D;
            4'h7: seg_raw = 7'h07;
            4'h8: seg_raw = 7'h7F;
            4'h9: seg_raw = 7'h6F;
            4'hA: seg_raw = 7'h5F;
            4'hB: seg_raw = 7'h7C;
            4'hC: seg_raw = 7'h58;
            4'hD: seg_raw = 7'h5E;
            4'hE: seg_raw = 7'h79;
            4'hF: seg_raw = 7'h71;
        endcase
    end

    always_comb begin
        lit   = disp_en_q[idx_q] && !lz_blank[idx_q] && duty_on;
        an_d  = lit ? (DIGITS'(1) << idx_q) : '0;
        seg_d = lit ? seg_raw : 7'h00;
        dp_d  = lit && disp_dp_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '0;
            pend_flag_q <= 1'b0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            disp_en_q   <= '0;
            a_to_g      <= '0;
            dp          <= 1'b0;
            an          <= '0;
            frame_done  <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_en_q   <= pend_en_d;
            pend_flag_q <= pend_flag_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_en_q   <= disp_en_d;
            a_to_g      <= seg_d;
            dp          <= dp_d;
            an          <= an_d;
            frame_done  <= wrap_tick;
            load_ack    <= wrap_tick && pend_flag_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_multi.sv
// Directed bench for seg7_scan_multi with DIGITS=4, DIV_BITS=3, BRIGHT_BITS=2 (32-cycle frames).
module tb_seg7_scan_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic [1:0]  brightness;
    logic [6:0]  a_to_g;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        load_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h5F, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

    seg7_scan_multi #(
        .DIGITS      (4),
        .DIV_BITS    (3),
        .BRIGHT_BITS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .brightness (brightness),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("rst_an", 32'(an), 0);
            check("rst_seg", 32'(a_to_g), 0);
            check("rst_dp", 32'(dp), 0);
            check("rst_fd", 32'(frame_done), 0);
            check("rst_ack", 32'(load_ack), 0);
        end
        rst = 1'b0;
    endtask

    // Starts right after reset release; the first wrap lands on the 32nd edge.
    task automatic idle_check(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            check($sformatf("idle_an c%0d", k), 32'(an), 0);
            check($sformatf("idle_seg c%0d", k), 32'(a_to_g), 0);
            check($sformatf("idle_dp c%0d", k), 32'(dp), 0);
            check($sformatf("idle_ack c%0d", k), 32'(load_ack), 0);
            check($sformatf("idle_fd c%0d", k), 32'(frame_done), 32'(k == 32));
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] en);
        value    = v;
        dp_in    = dpv;
        digit_en = en;
        load     = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
    endtask

    task automatic wait_frame(input int exp_cycles, input bit exp_ack);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (frame_done) seen = 1'b1;
        end
        check("wait_frame_seen", 32'(seen), 1);
        check("wait_frame_cycles", 32'(n), 32'(exp_cycles));
        check("wait_frame_ack", 32'(load_ack), 32'(exp_ack));
    endtask

    // Called just after a wrap edge (prescaler 0, index 0); checks one full frame.
    task automatic scan_frame(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] lit,
                              input logic [1:0] bright, input bit ack_end);
        bit         on;
        bit         last;
        logic [3:0] exp_an;
        brightness = bright;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                last   = (s == 3) && (k == 7);
                on     = lit[s] && ((k >> 1) < int'(bright));
                exp_an = on ? (4'b0001 << s) : 4'b0000;
                check($sformatf("an %h s%0d k%0d", v, s, k), 32'(an), 32'(exp_an));
                check($sformatf("seg %h s%0d k%0d", v, s, k), 32'(a_to_g),
                      on ? 32'(seg_tab[v[4*s +: 4]]) : 32'h0);
                check($sformatf("dp %h s%0d k%0d", v, s, k), 32'(dp), on ? 32'(dpv[s]) : 32'h0);
                check($sformatf("fd %h s%0d k%0d", v, s, k), 32'(frame_done), 32'(last));
                check($sformatf("ack %h s%0d k%0d", v, s, k), 32'(load_ack),
                      32'(last && ack_end));
            end
        end
    endtask

    logic [3:0] lit_lz;
    logic [3:0] lit_lz_dp;

    initial begin
        value      = '0;
        dp_in      = '0;
        digit_en   = '0;
        load       = 1'b0;
        brightness = 2'd3;
`ifdef SEG7_LZ_SUPPRESS_EN
        lit_lz    = 4'b0011;
        lit_lz_dp = 4'b0111;
`else
        lit_lz    = 4'b1111;
        lit_lz_dp = 4'b1111;
`endif

        // Reset and idle: nothing lit, first frame boundary only after 32 cycles.
        do_reset(3);
        idle_check(40);

        // Load and full-brightness scan.
        pulse_load(16'h12AF, 4'h0, 4'hF);
        wait_frame(23, 1'b1);
        scan_frame(16'h12AF, 4'h0, 4'hF, 2'd3, 1'b0);

        // Load landing on a wrap tick while other data is pending.
        pulse_load(16'h1111, 4'h0, 4'hF);
        repeat (30) @(posedge clk);
        #1;
        pulse_load(16'h2222, 4'h0, 4'hF);
        check("coll_ack1", 32'(load_ack), 1);
        check("coll_fd", 32'(frame_done), 1);
        scan_frame(16'h1111, 4'h0, 4'hF, 2'd3, 1'b1);
        scan_frame(16'h2222, 4'h0, 4'hF, 2'd3, 1'b0);

        // PWM duty: 2 of 8, then fully dark.
        scan_frame(16'h2222, 4'h0, 4'hF, 2'd1, 1'b0);
        scan_frame(16'h2222, 4'h0, 4'hF, 2'd0, 1'b0);

        // Leading zeros, then with a decimal point on an otherwise-leading digit.
        pulse_load(16'h0050, 4'h0, 4'hF);
        brightness = 2'd3;
        wait_frame(31, 1'b1);
        scan_frame(16'h0050, 4'h0, lit_lz, 2'd3, 1'b0);
        pulse_load(16'h0050, 4'b0100, 4'hF);
        wait_frame(31, 1'b1);
        scan_frame(16'h0050, 4'b0100, lit_lz_dp, 2'd3, 1'b0);

        // Reset with data pending: discarded, blank until a fresh load commits.
        pulse_load(16'h4321, 4'h0, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        do_reset(2);
        idle_check(40);
        pulse_load(16'h4321, 4'h0, 4'hF);
        wait_frame(23, 1'b1);
        scan_frame(16'h4321, 4'h0, 4'hF, 2'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
